// File: rtl/ofdm_pkg.sv
// Shared Hamming(7,4) definitions: codeword layout, syndrome positions, serializer states.
// The coder uses these constants to generate parity; the decoder uses them to check it.
package ofdm_pkg;

   localparam int unsigned D_LSB = 1;
   localparam int unsigned D_MSB = 4;
   localparam int unsigned P_LSB = 5;
   localparam int unsigned P_MSB = 7;

   localparam logic [2:0] SYN_NONE = 3'b000;
   localparam logic [2:0] SYN_P0   = 3'b001;
   localparam logic [2:0] SYN_P1   = 3'b010;
   localparam logic [2:0] SYN_P2   = 3'b100;
   localparam logic [2:0] SYN_D0   = 3'b011;
   localparam logic [2:0] SYN_D1   = 3'b110;
   localparam logic [2:0] SYN_D2   = 3'b111;
   localparam logic [2:0] SYN_D3   = 3'b101;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

   // Returns {p2,p1,p0} for data nibble {d3,d2,d1,d0}.
   function automatic logic [2:0] calc_parity(input logic [3:0] d);
      return {d[1] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2], d[0] ^ d[2] ^ d[3]};
   endfunction

   function automatic logic [3:0] correct_nibble(input logic [3:0] d, input logic [2:0] syn);
      logic [3:0] flip;
      case (syn)
         SYN_D0:  flip = 4'b0001;
         SYN_D1:  flip = 4'b0010;
         SYN_D2:  flip = 4'b0100;
         SYN_D3:  flip = 4'b1000;
         default: flip = 4'b0000;
      endcase
      return d ^ flip;
   endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Synchronous FIFO of DEPTH entries (power of 2); push and pop may coincide, including when full.
module nibble_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem_r [DEPTH];
   logic [AW:0]  wr_r;
   logic [AW:0]  rd_r;
   logic         do_push_s;
   logic         do_pop_s;

   assign empty     = (wr_r == rd_r);
   assign full      = (wr_r[AW] != rd_r[AW]) && (wr_r[AW-1:0] == rd_r[AW-1:0]);
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign dout      = mem_r[rd_r[AW-1:0]];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_r[AW-1:0]] <= din;
      end
   end

   // Read/write pointers with wrap bit for full/empty disambiguation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_r <= {(AW+1){1'b0}};
         rd_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wr_r <= wr_r + PTR_ONE;
         if (do_pop_s)  rd_r <= rd_r + PTR_ONE;
      end
   end

endmodule

// File: rtl/hamming_decoder.sv
// Hamming(7,4) decoder: single-error correction, nibble FIFO and bit serializer.
// Statistics counters are built only when HAMMING_DEC_STATS_EN is defined.
module hamming_decoder
   import ofdm_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in_word,
   input  logic             in_sig,
   output logic             out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             corr,
   output logic             ovf,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] word_cnt
);

   logic       unused_s;
   logic [3:0] dec_d_s;
   logic [2:0] dec_p_s;
   logic [2:0] syn_s;
   logic [3:0] fix_s;
   logic       dec_vld_r;
   logic [3:0] dec_nib_r;
   logic       dec_err_r;
   logic       corr_r;
   logic       ovf_r;
   logic       accept_s;
   logic       drop_s;
   logic       pop_s;
   logic       full_s;
   logic       empty_s;
   logic [3:0] fifo_dout_s;
   ser_state_t state_r, state_n;
   logic [3:0] sh_r, sh_n;
   logic [1:0] idx_r, idx_n;

   assign unused_s = in_word[0];

   // Syndrome computation and single-bit correction.
   always_comb begin
      dec_d_s = in_word[D_MSB:D_LSB];
      dec_p_s = in_word[P_MSB:P_LSB];
      syn_s   = dec_p_s ^ calc_parity(dec_d_s);
      fix_s   = correct_nibble(dec_d_s, syn_s);
   end

   // Decode register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_vld_r <= 1'b0;
         dec_nib_r <= 4'h0;
         dec_err_r <= 1'b0;
      end else begin
         dec_vld_r <= in_sig;
         if (in_sig) begin
            dec_nib_r <= fix_s;
            dec_err_r <= (syn_s != SYN_NONE);
         end
      end
   end

   // A full FIFO still takes the word if the serializer pops in the same cycle.
   assign accept_s = dec_vld_r && (!full_s || pop_s);
   assign drop_s   = dec_vld_r && full_s && !pop_s;

   // Correction pulse and sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         corr_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         corr_r <= dec_vld_r && dec_err_r;
         if (drop_s) ovf_r <= 1'b1;
      end
   end

   assign corr = corr_r;
   assign ovf  = ovf_r;

   nibble_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept_s),
      .pop   (pop_s),
      .din   (dec_nib_r),
      .dout  (fifo_dout_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Serializer state register; out is the shift register LSB.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         sh_r    <= 4'h0;
         idx_r   <= 2'd0;
      end else begin
         state_r <= state_n;
         sh_r    <= sh_n;
         idx_r   <= idx_n;
      end
   end

   // Serializer next state: reload straight after bit 3 so back-to-back nibbles have no bubble.
   always_comb begin
      state_n = state_r;
      sh_n    = sh_r;
      idx_n   = idx_r;
      pop_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               sh_n    = fifo_dout_s;
               idx_n   = 2'd0;
               state_n = SHIFT;
            end else begin
               state_n = IDLE;
            end
         end
         SHIFT: begin
            if (out_ready) begin
               if (idx_r == 2'd3) begin
                  idx_n = 2'd0;
                  if (!empty_s) begin
                     pop_s = 1'b1;
                     sh_n  = fifo_dout_s;
                  end else begin
                     sh_n    = 4'h0;
                     state_n = IDLE;
                  end
               end else begin
                  sh_n  = {1'b0, sh_r[3:1]};
                  idx_n = idx_r + 2'd1;
               end
            end else begin
               state_n = SHIFT;
            end
         end
         default: begin
            state_n = IDLE;
            sh_n    = 4'h0;
            idx_n   = 2'd0;
         end
      endcase
   end

   assign out       = sh_r[0];
   assign out_valid = (state_r == SHIFT);

`ifdef HAMMING_DEC_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] corr_cnt_r;
   logic [CNT_W-1:0] word_cnt_r;

   // Saturating statistics; corrections count even for dropped words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         corr_cnt_r <= {CNT_W{1'b0}};
         word_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (dec_vld_r && dec_err_r && (corr_cnt_r != CNT_MAX)) corr_cnt_r <= corr_cnt_r + CNT_ONE;
         if (accept_s && (word_cnt_r != CNT_MAX)) word_cnt_r <= word_cnt_r + CNT_ONE;
      end
   end

   assign corr_cnt = corr_cnt_r;
   assign word_cnt = word_cnt_r;
`else
   assign corr_cnt = {CNT_W{1'b0}};
   assign word_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Receive-side companion to the Hamming(7,4) coder. It accepts 8-bit coded words, computes the 3-bit syndrome and corrects any single-bit error. Corrected 4-bit nibbles are buffered in a small FIFO and re-serialised one bit per handshake to the downstream bit consumer. It sits directly downstream of the coder, optionally after the channel/error-injection model.

## Interface
- `DEPTH`, 4: nibble FIFO depth in words; must be a power of 2, ≥2.
- `CNT_W`, 8: width of statistics counters.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_word`  in  8  coded word. Layout: [0] = 0 (ignored); [4:1] = d3..d0; [7:5] = p2..p0.
- `in_sig`  in  1  one-cycle strobe; `in_word` is valid when high. There is no backpressure.
- `out`  out  1  serial data bit, d0 first.
- `out_valid`  out  1  `out` holds a valid bit.
- `out_ready`  in  1  consumer accepts `out` this cycle.
- `corr`  out  1  one-cycle pulse: the word just written had a nonzero syndrome.
- `ovf`  out  1  sticky: a word arrived while the FIFO was full and was dropped.
- `corr_cnt`  out  CNT_W  saturating count of nonzero-syndrome words.
- `word_cnt`  out  CNT_W  saturating count of accepted words.

## Operation
- **Parity definition:** p0 = d0^d2^d3; p1 = d0^d1^d2; p2 = d1^d2^d3.
- **Syndrome:** s = {s2,s1,s0}, where si = pi XOR recomputed pi.
- **Error position by syndrome:**
  - 000: none.
  - 001: p0. 010: p1. 100: p2. Data passes unchanged for these three.
  - 011: d0. 110: d1. 111: d2. 101: d3. The indicated data bit is flipped.
- **Double errors:** miscorrected silently. There is no detection beyond the syndrome.
- **Stage 1 (decode register):** on `in_sig`, register the corrected nibble and the nonzero-syndrome flag.
- **Stage 2 (FIFO push):** the registered nibble is pushed one cycle after sampling.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped and `ovf` is set.
  - A push while full with a simultaneous pop is accepted.
  - `word_cnt` increments only on accepted pushes.
  - `corr` pulses and `corr_cnt` increments for every decoded word with a nonzero syndrome, including dropped ones.
- **Serializer FSM:**
  - IDLE: `out_valid` = 0. When the FIFO is non-empty, pop a nibble, load the shift register, set bit index to 0, go to SHIFT.
  - SHIFT: `out_valid` = 1 and `out` = current bit. On `out_valid && out_ready`, advance the index.
  - After bit 3 is accepted: if the FIFO is non-empty, load the next nibble in the same cycle (no bubble); otherwise return to IDLE.
- `out` stays stable while `out_valid && !out_ready`.
- Both counters saturate at all-ones and do not wrap.
- `in_word[0]` is ignored.

## Timing
- **Reset values:** `out`=0, `out_valid`=0, `corr`=0, `ovf`=0, `corr_cnt`=0, `word_cnt`=0. FIFO is empty; FSM is in IDLE.
- **Latency:** `in_sig` sampled at edge N → FIFO write at edge N+1 → serializer load at edge N+2 (if idle) → `out_valid` high after N+2.
- `corr` is high in the cycle after edge N+1 (aligned with the push).
- **Throughput:** up to one nibble per 4 cycles when `out_ready` is tied high, matching the coder rate.
- **Back-to-back `in_sig`:** each cycle's strobe is a separate word; the decode stage is fully pipelined.
- **Reset asserted mid-operation:** all state clears immediately and in-flight nibbles are discarded. `ovf` clears only on reset.

## Configuration
- `HAMMING_DEC_STATS_EN`
  - Defined: `corr_cnt` and `word_cnt` counters are built and behave as above.
  - Undefined: both outputs are tied to 0 and the counter logic is absent. `corr` and `ovf` remain.

## Structure
- **Shared package `ofdm_pkg`:**
  - Codeword bit-index constants: D_LSB=1, D_MSB=4, P_LSB=5, P_MSB=7.
  - Serializer state enum: IDLE, SHIFT.
  - Syndrome-to-position constants, used by the coder for generation and by this block for checking.
- **Sub-module `nibble_fifo`:** parameterised synchronous FIFO with DEPTH entries of width 4, full/empty flags, and push/pop allowed in the same cycle.

## Test plan
- No errors: words 0x16 (data 1011) then 0x62 (data 0001), `out_ready`=1 → `out` sequence 1,1,0,1,1,0,0,0; `corr` never pulses; `word_cnt`=2.
- Data error: 0x1E (d2 flipped) → syndrome 111; output 1,1,0,1; one `corr` pulse; `corr_cnt`=1.
- Parity error: 0xE2 (p2 flipped) → syndrome 100; output 1,0,0,0; `corr` pulses.
- Backpressure: `out_ready`=0, push DEPTH+1 words → `ovf`=1 and exactly DEPTH nibbles drain in order once `out_ready`=1.
- Stall stability: toggle `out_ready` randomly → `out` never changes while `out_valid && !out_ready`; no bits lost or duplicated.
- Reset mid-stream: assert `reset` low during bit 2 → next cycle `out_valid`=0, counters=0, FIFO empty; later 0x16 decodes normally.
